pwm_density_meter: RTL and testbench
====================================

// Module: pwm_density_meter
// PURPOSE
//  Receive-side counterpart of the LED PWM / first-order delta-sigma driver: recovers the duty
//  value from a 1-bit pulse-density stream on an asynchronous pin. Counts high samples over a
//  fixed window of 2^WIN_LOG2 clocks and reports a DUTY_W-bit duty code with a 1-cycle VALID
//  strobe. Also flags a stuck (edge-free) line. Used for loopback test of the PWM driver and
//  for reading external PWM/PDM sensors on the TinyFPGA BX (16 MHz CLK).
// PARAMETERS
//  WIN_LOG2     8  log2 of window length in clocks; must satisfy WIN_LOG2 >= DUTY_W
//  DUTY_W       4  width of the DUTY output code
//  SYNC_STAGES  2  flops in the PIN synchronizer chain; must be >= 2
// PORTS
//  CLK    in   1        16 MHz system clock; all logic on posedge
//  RST_N  in   1        asynchronous, active-low reset
//  EN     in   1        measurement enable; level-sensitive
//  PIN    in   1        asynchronous pulse-density input
//  DUTY   out  DUTY_W   duty code of the last completed window
//  VALID  out  1        one-cycle strobe: DUTY/STUCK/LEVEL updated this cycle
//  STUCK  out  1        last completed window contained no edge
//  LEVEL  out  1        synchronized PIN level at end of last window (meaningful when STUCK)
// BEHAVIOUR
//  Reset: DUTY=0, VALID=0, STUCK=0, LEVEL=0; sync chain, counters, state cleared; state IDLE.
//  Sync: PIN passes SYNC_STAGES flops -> s; edge = s ^ s_d (s_d = s delayed one cycle). Sync
//   flops reset to 0; they run regardless of EN.
//  FSM IDLE: counters held at 0, VALID=0. EN=1 -> PRIME.
//   PRIME: SYNC_STAGES cycles; loads s_d; no counting (flushes stale sync data). Then -> RUN.
//   RUN: win_cnt (WIN_LOG2 bits) increments every cycle from 0; hi_cnt (WIN_LOG2+1 bits)
//   += s; edge_seen |= edge. On terminal cycle (win_cnt = all ones), with
//   sum = hi_cnt + s (this cycle's sample included):
//    next cycle DUTY = sum >> (WIN_LOG2-DUTY_W), saturated to all-ones when
//    sum = 2^WIN_LOG2; STUCK = ~(edge_seen | edge); LEVEL = s; VALID = 1 for exactly one
//    cycle; win_cnt wraps to 0 and hi_cnt/edge_seen clear. Windows are back-to-back: no gap
//    cycle; first VALID appears 2^WIN_LOG2 + SYNC_STAGES + 1 cycles after EN rises.
//   EN=0 in any state -> IDLE next cycle; a partial window is discarded (no VALID).
//   DUTY/STUCK/LEVEL hold their values.
//  Width: hi_cnt cannot overflow (max 2^WIN_LOG2). The shift truncates; no rounding.
//  Async reset asserted mid-window: all state to reset values immediately; no VALID on release.
//  Accuracy: a first-order delta-sigma source of code x over 2^DUTY_W-cycle period yields
//   exactly DUTY = x for any window alignment (window is a multiple of the period).
// STRUCTURE
//  Shared package pwm_pkg: DUTY_W default, WIN_LOG2 default, FSM state encoding
//   (IDLE/PRIME/RUN) shared with the PWM driver bench.
//  Sub-module pin_sync (SYNC_STAGES flop chain, async active-low reset) instantiated once;
//   also reused for button inputs.
// TESTING
//  1 PIN=1 const, EN=1 -> VALID every 256 clk; DUTY=15 (saturated), STUCK=1, LEVEL=1.
//  2 PIN=0 const -> DUTY=0, STUCK=1, LEVEL=0.
//  3 PIN from reference PWM driver, code 8 (1010...) -> DUTY=8, STUCK=0, every window.
//  4 Sweep driver codes 0..15 with random phase vs window start -> DUTY equals code.
//    Exception: code 0 -> DUTY=0, STUCK=1.
//  5 EN dropped at win_cnt=100 then re-raised -> no VALID for partial window; next VALID
//    exactly 256+SYNC_STAGES+1 clk after re-raise; DUTY holds meanwhile.
//  6 RST_N pulsed low mid-window (async, off clock edge) -> outputs 0 at once.
//    After release with EN=1, first VALID after full latency, correct DUTY.

Source files
------------

// File: rtl/pwm_density_meter_pkg.sv
// Shared defaults and FSM state encoding for the PWM driver / density meter pair.
package pwm_density_meter_pkg;

   localparam int DUTY_W_DEF      = 4;
   localparam int WIN_LOG2_DEF    = 8;
   localparam int SYNC_STAGES_DEF = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input (pins, buttons).
module pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw pin through the synchronizer chain
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_density_meter.sv
// Recovers a duty code from a pulse-density pin by counting high samples over a
// fixed power-of-two window; also reports stuck (edge-free) windows.
module pwm_density_meter
   import pwm_density_meter_pkg::*;
#(
   parameter int WIN_LOG2    = WIN_LOG2_DEF,
   parameter int DUTY_W      = DUTY_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              pin_i,
   output logic [DUTY_W-1:0] duty_o,
   output logic              valid_o,
   output logic              stuck_o,
   output logic              level_o
);

   localparam int SHIFT   = WIN_LOG2 - DUTY_W;
   localparam int PRIME_W = $clog2(SYNC_STAGES);

   localparam logic [PRIME_W-1:0]  PRIME_LAST = PRIME_W'(SYNC_STAGES - 1);
   localparam logic [PRIME_W-1:0]  PRIME_ONE  = {{(PRIME_W-1){1'b0}}, 1'b1};
   localparam logic [WIN_LOG2-1:0] WIN_ONE    = {{(WIN_LOG2-1){1'b0}}, 1'b1};

   logic                s_s;
   logic                edge_s;
   logic                term_s;
   logic [WIN_LOG2:0]   sum_s;
   logic [WIN_LOG2:0]   sum_scaled_s;
   logic [WIN_LOG2:0]   unused_scaled_s;
   logic [DUTY_W-1:0]   code_s;

   logic                s_d_q;
   logic [1:0]          state_q, state_d;
   logic [PRIME_W-1:0]  prime_q, prime_d;
   logic [WIN_LOG2-1:0] win_q, win_d;
   logic [WIN_LOG2:0]   hi_q, hi_d;
   logic                seen_q, seen_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic                stuck_q, stuck_d;
   logic                level_q, level_d;
   logic                valid_q, valid_d;

   pin_sync #(
      .STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pin_i),
      .q_o    (s_s)
   );

   assign edge_s = s_s ^ s_d_q;
   assign term_s = &win_q;
   // The terminal sample is folded in here so the window sees exactly 2^WIN_LOG2 samples
   assign sum_s           = hi_q + {{WIN_LOG2{1'b0}}, s_s};
   assign sum_scaled_s    = sum_s >> SHIFT;
   assign unused_scaled_s = sum_scaled_s;
   assign code_s          = sum_scaled_s[DUTY_W] ? {DUTY_W{1'b1}} : sum_scaled_s[DUTY_W-1:0];

   // Next-state logic for the measurement FSM, window counters and result registers
   always_comb begin
      state_d = state_q;
      prime_d = prime_q;
      win_d   = win_q;
      hi_d    = hi_q;
      seen_d  = seen_q;
      duty_d  = duty_q;
      stuck_d = stuck_q;
      level_d = level_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            prime_d = {PRIME_W{1'b0}};
            win_d   = {WIN_LOG2{1'b0}};
            hi_d    = {(WIN_LOG2+1){1'b0}};
            seen_d  = 1'b0;
            if (en_i) begin
               state_d = ST_PRIME;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRIME: begin
            if (!en_i) begin
               state_d = ST_IDLE;
               prime_d = {PRIME_W{1'b0}};
            end else if (prime_q == PRIME_LAST) begin
               state_d = ST_RUN;
               prime_d = {PRIME_W{1'b0}};
            end else begin
               prime_d = prime_q + PRIME_ONE;
            end
         end
         ST_RUN: begin
            if (!en_i) begin
               state_d = ST_IDLE;
               win_d   = {WIN_LOG2{1'b0}};
               hi_d    = {(WIN_LOG2+1){1'b0}};
               seen_d  = 1'b0;
            end else if (term_s) begin
               duty_d  = code_s;
               stuck_d = ~(seen_q | edge_s);
               level_d = s_s;
               valid_d = 1'b1;
               win_d   = {WIN_LOG2{1'b0}};
               hi_d    = {(WIN_LOG2+1){1'b0}};
               seen_d  = 1'b0;
            end else begin
               win_d  = win_q + WIN_ONE;
               hi_d   = sum_s;
               seen_d = seen_q | edge_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
            prime_d = {PRIME_W{1'b0}};
            win_d   = {WIN_LOG2{1'b0}};
            hi_d    = {(WIN_LOG2+1){1'b0}};
            seen_d  = 1'b0;
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_d_q   <= 1'b0;
         state_q <= ST_IDLE;
         prime_q <= {PRIME_W{1'b0}};
         win_q   <= {WIN_LOG2{1'b0}};
         hi_q    <= {(WIN_LOG2+1){1'b0}};
         seen_q  <= 1'b0;
         duty_q  <= {DUTY_W{1'b0}};
         stuck_q <= 1'b0;
         level_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         s_d_q   <= s_s;
         state_q <= state_d;
         prime_q <= prime_d;
         win_q   <= win_d;
         hi_q    <= hi_d;
         seen_q  <= seen_d;
         duty_q  <= duty_d;
         stuck_q <= stuck_d;
         level_q <= level_d;
         valid_q <= valid_d;
      end
   end

   assign duty_o  = duty_q;
   assign valid_o = valid_q;
   assign stuck_o = stuck_q;
   assign level_o = level_q;

endmodule

// File: tb/tb_pwm_density_meter.sv
// Scoreboard bench for pwm_density_meter: windows are modelled as slots of driven pin values.
module tb_pwm_density_meter;

   localparam int N  = 256;
   localparam int S  = 2;
   localparam int DW = 4;
   localparam int P  = 1 << DW;

   typedef struct {
      int duty;
      int stuck;
      int level;
      int due;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          en_i;
   logic          pin_i;
   logic [DW-1:0] duty_o;
   logic          valid_o;
   logic          stuck_o;
   logic          level_o;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];
   exp_t held;
   exp_t pend;
   bit   pend_v;
   int   pend_rel;
   bit   run;
   int   rel;
   int   hi;
   bit   eg;
   bit   prev;
   int   acc;

   pwm_density_meter #(
      .WIN_LOG2    (8),
      .DUTY_W      (DW),
      .SYNC_STAGES (S)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (en_i),
      .pin_i   (pin_i),
      .duty_o  (duty_o),
      .valid_o (valid_o),
      .stuck_o (stuck_o),
      .level_o (level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int duty_of(input int highs);
      int d;
      d = (highs * P) / N;
      if (d > P - 1) d = P - 1;
      return d;
   endfunction

   // One drive slot: the window opened by raising EN covers slots 1..N, N+1..2N, ...
   task automatic drive(input bit en, input bit pin);
      @(posedge clk);
      #1;
      en_i  = en;
      pin_i = pin;
      if (!en) begin
         run    = 1'b0;
         pend_v = 1'b0;
      end else if (!run) begin
         run    = 1'b1;
         rel    = 0;
         prev   = pin;
         hi     = 0;
         eg     = 1'b0;
         pend_v = 1'b0;
      end else begin
         rel++;
         hi += int'(pin);
         if (pin != prev) eg = 1'b1;
         prev = pin;
         if (pend_v && rel == pend_rel) begin
            pend.due = cyc + 1;
            sb.push_back(pend);
            pend_v = 1'b0;
         end
         if (rel % N == 0) begin
            pend.duty  = duty_of(hi);
            pend.stuck = eg ? 0 : 1;
            pend.level = int'(pin);
            pend.due   = 0;
            pend_rel   = rel + S;
            pend_v     = 1'b1;
            hi         = 0;
            eg         = 1'b0;
         end
      end
   endtask

   // mode 0: const 0, 1: const 1, 2: first-order delta-sigma of code, 3: random with code% density
   task automatic gen(input int mode, input int code, output bit pin);
      case (mode)
         0: pin = 1'b0;
         1: pin = 1'b1;
         2: begin
            acc = acc + code;
            pin = (acc >= P);
            acc = acc % P;
         end
         default: pin = ($urandom_range(0, 99) < code);
      endcase
   endtask

   task automatic run_seg(input int mode, input int code, input int nwin);
      bit p;
      int pre;
      pre = $urandom_range(3, 12);
      for (int i = 0; i < pre; i++) begin
         gen(mode, code, p);
         drive(1'b0, p);
      end
      for (int i = 0; i <= nwin * N + S; i++) begin
         gen(mode, code, p);
         drive(1'b1, p);
      end
   endtask

   // Scoreboard monitor: pop on VALID, otherwise outputs must hold the last result
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("missing_valid", 0, 1);
            void'(sb.pop_front());
         end
         if (valid_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               held = sb.pop_front();
               chk("valid_time", cyc, held.due);
               chk("duty", int'(duty_o), held.duty);
               chk("stuck", int'(stuck_o), held.stuck);
               chk("level", int'(level_o), held.level);
            end
         end else begin
            chk("hold_duty", int'(duty_o), held.duty);
            chk("hold_stuck", int'(stuck_o), held.stuck);
            chk("hold_level", int'(level_o), held.level);
         end
      end
   end

   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      en_i  = 1'b0;
      #1;
      chk("rst_duty", int'(duty_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_stuck", int'(stuck_o), 0);
      chk("rst_level", int'(level_o), 0);
      sb.delete();
      run    = 1'b0;
      pend_v = 1'b0;
      held   = '{0, 0, 0, 0};
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      bit p;
      rst_n  = 1'b0;
      en_i   = 1'b0;
      pin_i  = 1'b0;
      run    = 1'b0;
      pend_v = 1'b0;
      held   = '{0, 0, 0, 0};
      acc    = $urandom_range(0, P - 1);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_duty", int'(duty_o), 0);
      chk("reset_valid", int'(valid_o), 0);
      chk("reset_stuck", int'(stuck_o), 0);
      chk("reset_level", int'(level_o), 0);
      #1;
      rst_n = 1'b1;

      run_seg(1, 0, 3);
      run_seg(0, 0, 2);
      acc = 0;
      run_seg(2, 8, 2);
      for (int c = 0; c < P; c++) begin
         acc = $urandom_range(0, P - 1);
         run_seg(2, c, 1);
      end
      run_seg(3, 37, 2);
      run_seg(3, 81, 1);

      // EN dropped part-way through a window, then re-raised
      acc = $urandom_range(0, P - 1);
      run_seg(2, 11, 1);
      for (int i = 0; i < S + 101; i++) begin
         gen(2, 3, p);
         drive(1'b1, p);
      end
      for (int i = 0; i < 5; i++) begin
         gen(2, 3, p);
         drive(1'b0, p);
      end
      for (int i = 0; i <= N + S + 2; i++) begin
         gen(2, 3, p);
         drive(1'b1, p);
      end

      // Async reset in the middle of a running window
      run_seg(1, 0, 1);
      for (int i = 0; i < 50; i++) drive(1'b1, 1'b1);
      mid_reset();
      acc = $urandom_range(0, P - 1);
      run_seg(2, 5, 1);

      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
